// File: rtl/game_end_pkg.sv
// Shared constants, state/mode encodings and the glyph rectangle list for the
// "TOO / LATE" end-of-game screen.
package game_end_pkg;

  localparam int unsigned OLED_W = 96;
  localparam int unsigned OLED_H = 64;

  localparam logic [15:0] COL_BLACK = 16'h0000;
  localparam logic [15:0] COL_WHITE = 16'hFFFF;

  typedef enum logic [1:0] {
    StIdle,
    StEnter,
    StHold,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    ModeStatic = 2'd0,
    ModeBlink  = 2'd1,
    ModeScroll = 2'd2,
    ModeInvert = 2'd3
  } mode_e;

  // Inclusive rectangle in text-local coordinates.
  typedef struct packed {
    logic [6:0] x0;
    logic [6:0] x1;
    logic [5:0] y0;
    logic [5:0] y1;
  } rect_t;

  localparam int unsigned NumRects = 22;

  localparam rect_t TextRects [NumRects] = '{
    '{7'd8,  7'd20, 6'd9,  6'd11}, '{7'd12, 7'd17, 6'd12, 6'd23},
    '{7'd24, 7'd29, 6'd9,  6'd23}, '{7'd30, 7'd32, 6'd9,  6'd11},
    '{7'd30, 7'd32, 6'd21, 6'd23}, '{7'd33, 7'd35, 6'd9,  6'd23},
    '{7'd39, 7'd44, 6'd9,  6'd23}, '{7'd45, 7'd47, 6'd9,  6'd11},
    '{7'd45, 7'd47, 6'd21, 6'd23}, '{7'd48, 7'd50, 6'd9,  6'd23},
    '{7'd9,  7'd14, 6'd39, 6'd50}, '{7'd9,  7'd20, 6'd51, 6'd53},
    '{7'd24, 7'd29, 6'd39, 6'd53}, '{7'd30, 7'd32, 6'd39, 6'd41},
    '{7'd30, 7'd32, 6'd45, 6'd47}, '{7'd33, 7'd35, 6'd39, 6'd53},
    '{7'd39, 7'd50, 6'd39, 6'd41}, '{7'd42, 7'd47, 6'd42, 6'd53},
    '{7'd54, 7'd59, 6'd39, 6'd53}, '{7'd60, 7'd65, 6'd39, 6'd41},
    '{7'd60, 7'd62, 6'd45, 6'd47}, '{7'd60, 7'd65, 6'd51, 6'd53}
  };

  function automatic logic in_rect(rect_t r, logic [6:0] u, logic [5:0] v);
    return (u >= r.x0) && (u <= r.x1) && (v >= r.y0) && (v <= r.y1);
  endfunction

endpackage

// File: rtl/end_text_mask.sv
// Combinational text mask: hit is high when (u, v) lies inside any glyph rectangle.
module end_text_mask
  import game_end_pkg::*;
(
  input  logic [6:0] u,
  input  logic [5:0] v,
  output logic       hit
);

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NumRects; i++) begin
      if (in_rect(TextRects[i], u, v)) hit = 1'b1;
    end
  end

endmodule

// File: rtl/game_end_screen.sv
// End-of-game screen: sequencing FSM, per-frame effect counters and the registered
// pixel colour for the OLED pipeline.
module game_end_screen
  import game_end_pkg::*;
#(
  parameter logic [15:0] FG_COLOUR    = COL_BLACK,
  parameter logic [15:0] BG_COLOUR    = COL_WHITE,
  parameter int unsigned HOLD_FRAMES  = 120,
  parameter int unsigned BLINK_FRAMES = 15,
  parameter int unsigned SCROLL_STEP  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_begin,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic [6:0]  x,
  input  logic [5:0]  y,
  output logic [15:0] oled_data,
  output logic        active,
  output logic        done
);

  localparam logic [7:0] HoldLast  = 8'(HOLD_FRAMES - 1);
  localparam logic [7:0] BlinkLast = 8'(BLINK_FRAMES - 1);
  localparam logic [7:0] Step      = 8'(SCROLL_STEP);
  localparam logic [6:0] OffStart  = 7'(OLED_W);

  state_e      state_q, state_d;
  mode_e       mode_q, mode_d;
  logic [6:0]  offset_q, offset_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [7:0]  blink_cnt_q, blink_cnt_d;
  logic        phase_q, phase_d;
  logic [15:0] oled_data_q, oled_data_d;
  logic        active_q, active_d;
  logic        done_q, done_d;

  logic [7:0]  off_sub;
  logic [6:0]  off_next;
  logic        past_off;
  logic [6:0]  u;
  logic        mask_hit;
  logic        text_hit;

  end_text_mask u_mask (
    .u   (u),
    .v   (y),
    .hit (mask_hit)
  );

  // Bit 7 of the 8-bit difference flags underflow; clamp to the left edge.
  assign off_sub  = {1'b0, offset_q} - Step;
  assign off_next = off_sub[7] ? 7'd0 : off_sub[6:0];

  assign past_off = (x >= offset_q);
  assign u        = past_off ? (x - offset_q) : 7'd0;
  assign text_hit = past_off && mask_hit;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    offset_d    = offset_q;
    frame_cnt_d = frame_cnt_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;

    if (start) begin
      mode_d      = mode_e'(mode);
      frame_cnt_d = 8'd0;
      blink_cnt_d = 8'd0;
      phase_d     = 1'b0;
      if (mode_e'(mode) == ModeScroll) begin
        offset_d = OffStart;
        state_d  = StEnter;
      end else begin
        offset_d = 7'd0;
        state_d  = StHold;
      end
    end else if (frame_begin) begin
      unique case (state_q)
        StEnter: begin
          offset_d = off_next;
          if (off_next == 7'd0) begin
            state_d     = StHold;
            frame_cnt_d = 8'd0;
            blink_cnt_d = 8'd0;
            phase_d     = 1'b0;
          end
        end
        StHold: begin
          frame_cnt_d = frame_cnt_q + 8'd1;
          if (frame_cnt_q == HoldLast) state_d = StDone;
          if (blink_cnt_q == BlinkLast) begin
            blink_cnt_d = 8'd0;
            phase_d     = ~phase_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end

    active_d = (state_d == StEnter) || (state_d == StHold);
    done_d   = (state_d == StDone);
  end

  // Colour reflects the state before this cycle's update.
  always_comb begin
    oled_data_d = BG_COLOUR;
    unique case (state_q)
      StEnter, StDone: oled_data_d = text_hit ? FG_COLOUR : BG_COLOUR;
      StHold: begin
        if (phase_q && (mode_q == ModeBlink)) begin
          oled_data_d = BG_COLOUR;
        end else if (phase_q && (mode_q == ModeInvert)) begin
          oled_data_d = text_hit ? BG_COLOUR : FG_COLOUR;
        end else begin
          oled_data_d = text_hit ? FG_COLOUR : BG_COLOUR;
        end
      end
      default: oled_data_d = BG_COLOUR;
    endcase
    // y is only 6 bits wide so it can never exceed the panel height.
    if (x >= 7'(OLED_W)) oled_data_d = BG_COLOUR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      mode_q      <= ModeStatic;
      offset_q    <= 7'd0;
      frame_cnt_q <= 8'd0;
      blink_cnt_q <= 8'd0;
      phase_q     <= 1'b0;
      oled_data_q <= BG_COLOUR;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      offset_q    <= offset_d;
      frame_cnt_q <= frame_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      oled_data_q <= oled_data_d;
      active_q    <= active_d;
      done_q      <= done_d;
    end
  end

  assign oled_data = oled_data_q;
  assign active    = active_q;
  assign done      = done_q;

endmodule

// File: tb/tb_game_end_screen.sv
// Bench for game_end_screen: two differently parameterised instances share stimulus and are
// compared every cycle against a frame-level behavioural model.
module tb_game_end_screen;

  localparam logic [15:0] FG_A = 16'h0000;
  localparam logic [15:0] BG_A = 16'hFFFF;
  localparam logic [15:0] FG_B = 16'hF800;
  localparam logic [15:0] BG_B = 16'h07E0;
  localparam int HOLD_A = 12, BLINK_A = 4, STEP_A = 8;
  localparam int HOLD_B = 1, BLINK_B = 1, STEP_B = 96;

  localparam int M_IDLE = 0, M_ENTER = 1, M_HOLD = 2, M_DONE = 3;

  logic        clk = 1'b0;
  logic        reset, frame_begin, start;
  logic [1:0]  mode;
  logic [6:0]  x;
  logic [5:0]  y;
  logic [15:0] oled_a, oled_b;
  logic        active_a, active_b, done_a, done_b;

  always #5 clk = ~clk;

  game_end_screen #(
    .FG_COLOUR(FG_A), .BG_COLOUR(BG_A),
    .HOLD_FRAMES(HOLD_A), .BLINK_FRAMES(BLINK_A), .SCROLL_STEP(STEP_A)
  ) dut_a (
    .clk(clk), .reset(reset), .frame_begin(frame_begin), .start(start), .mode(mode),
    .x(x), .y(y), .oled_data(oled_a), .active(active_a), .done(done_a)
  );

  game_end_screen #(
    .FG_COLOUR(FG_B), .BG_COLOUR(BG_B),
    .HOLD_FRAMES(HOLD_B), .BLINK_FRAMES(BLINK_B), .SCROLL_STEP(STEP_B)
  ) dut_b (
    .clk(clk), .reset(reset), .frame_begin(frame_begin), .start(start), .mode(mode),
    .x(x), .y(y), .oled_data(oled_b), .active(active_b), .done(done_b)
  );

  int checks = 0;
  int failures = 0;

  // Model: sequence phase, chosen effect, text offset and frames elapsed in HOLD.
  int m_state [2];
  int m_mode  [2];
  int m_off   [2];
  int m_frames[2];

  int rects [22][4] = '{
    '{8, 20, 9, 11}, '{12, 17, 12, 23},
    '{24, 29, 9, 23}, '{30, 32, 9, 11}, '{30, 32, 21, 23}, '{33, 35, 9, 23},
    '{39, 44, 9, 23}, '{45, 47, 9, 11}, '{45, 47, 21, 23}, '{48, 50, 9, 23},
    '{9, 14, 39, 50}, '{9, 20, 51, 53},
    '{24, 29, 39, 53}, '{30, 32, 39, 41}, '{30, 32, 45, 47}, '{33, 35, 39, 53},
    '{39, 50, 39, 41}, '{42, 47, 42, 53},
    '{54, 59, 39, 53}, '{60, 65, 39, 41}, '{60, 62, 45, 47}, '{60, 65, 51, 53}
  };

  function automatic int p_hold(int id);  return (id == 0) ? HOLD_A : HOLD_B;   endfunction
  function automatic int p_blink(int id); return (id == 0) ? BLINK_A : BLINK_B; endfunction
  function automatic int p_step(int id);  return (id == 0) ? STEP_A : STEP_B;   endfunction
  function automatic logic [15:0] p_fg(int id); return (id == 0) ? FG_A : FG_B; endfunction
  function automatic logic [15:0] p_bg(int id); return (id == 0) ? BG_A : BG_B; endfunction

  function automatic bit text_at(int u, int v);
    for (int i = 0; i < 22; i++) begin
      if (u >= rects[i][0] && u <= rects[i][1] && v >= rects[i][2] && v <= rects[i][3])
        return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [15:0] model_pixel(int id, int px, int py);
    bit hit;
    bit odd;
    if (px >= 96 || py >= 64 || m_state[id] == M_IDLE) return p_bg(id);
    hit = (px >= m_off[id]) && text_at(px - m_off[id], py);
    odd = ((m_frames[id] / p_blink(id)) % 2) == 1;
    if (m_state[id] == M_HOLD && odd && m_mode[id] == 1) return p_bg(id);
    if (m_state[id] == M_HOLD && odd && m_mode[id] == 3) return hit ? p_bg(id) : p_fg(id);
    return hit ? p_fg(id) : p_bg(id);
  endfunction

  task automatic model_step(int id, bit rst, bit st, bit fb, int md);
    if (rst) begin
      m_state[id] = M_IDLE; m_mode[id] = 0; m_off[id] = 0; m_frames[id] = 0;
    end else if (st) begin
      m_mode[id] = md;
      m_frames[id] = 0;
      m_off[id] = (md == 2) ? 96 : 0;
      m_state[id] = (md == 2) ? M_ENTER : M_HOLD;
    end else if (fb) begin
      if (m_state[id] == M_ENTER) begin
        m_off[id] = m_off[id] - p_step(id);
        if (m_off[id] <= 0) begin
          m_off[id] = 0; m_state[id] = M_HOLD; m_frames[id] = 0;
        end
      end else if (m_state[id] == M_HOLD) begin
        m_frames[id]++;
        if (m_frames[id] >= p_hold(id)) m_state[id] = M_DONE;
      end
    end
  endtask

  task automatic check16(string tag, logic [15:0] got, logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check1(string tag, logic got, logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, advance, then compare both DUTs with the model.
  task automatic step(string tag, bit rst, bit st, bit fb, int md, int px, int py);
    logic [15:0] exp_pix [2];
    reset = rst; start = st; frame_begin = fb; mode = 2'(md); x = 7'(px); y = 6'(py);
    for (int id = 0; id < 2; id++) exp_pix[id] = rst ? p_bg(id) : model_pixel(id, px, py);
    @(posedge clk);
    #1;
    for (int id = 0; id < 2; id++) model_step(id, rst, st, fb, md);
    check16({tag, "_pix_a"}, oled_a, exp_pix[0]);
    check16({tag, "_pix_b"}, oled_b, exp_pix[1]);
    check1({tag, "_act_a"}, active_a, m_state[0] == M_ENTER || m_state[0] == M_HOLD);
    check1({tag, "_act_b"}, active_b, m_state[1] == M_ENTER || m_state[1] == M_HOLD);
    check1({tag, "_done_a"}, done_a, m_state[0] == M_DONE);
    check1({tag, "_done_b"}, done_b, m_state[1] == M_DONE);
  endtask

  task automatic frames(string tag, int n);
    for (int i = 0; i < n; i++) begin
      step(tag, 0, 0, 1, 0, 10, 10);
      step(tag, 0, 0, 0, 0, 20, 50);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; frame_begin = 1'b0; mode = 2'd0; x = '0; y = '0;
    for (int id = 0; id < 2; id++) begin
      m_state[id] = M_IDLE; m_mode[id] = 0; m_off[id] = 0; m_frames[id] = 0;
    end

    step("reset", 1, 0, 0, 0, 10, 10);
    step("reset", 1, 1, 1, 2, 10, 10);
    check16("reset_bg", oled_a, BG_A);
    check1("reset_active", active_a, 1'b0);
    step("idle", 0, 0, 0, 0, 10, 10);
    check16("idle_bg", oled_a, BG_A);

    // Static
    step("st_start", 0, 1, 0, 0, 10, 10);
    step("st_px", 0, 0, 0, 0, 10, 10);
    check16("static_10_10", oled_a, FG_A);
    step("st_px", 0, 0, 0, 0, 31, 15);
    check16("static_hole", oled_a, BG_A);
    step("st_px", 0, 0, 0, 0, 0, 0);
    check16("static_origin", oled_a, BG_A);
    frames("st_frames", HOLD_A - 1);
    check1("static_not_done", done_a, 1'b0);
    step("st_last", 0, 0, 1, 0, 10, 10);
    check1("static_done", done_a, 1'b1);
    check1("static_inactive", active_a, 1'b0);
    step("st_donepx", 0, 0, 0, 0, 10, 10);
    check16("done_text", oled_a, FG_A);

    // Scroll-in
    step("sc_start", 0, 1, 0, 2, 10, 10);
    step("sc_px", 0, 0, 0, 0, 10, 10);
    check16("scroll_start_bg", oled_a, BG_A);
    frames("sc_frames", 11);
    step("sc_px", 0, 0, 0, 0, 18, 10);
    check16("scroll_off8_fg", oled_a, FG_A);
    step("sc_px", 0, 0, 0, 0, 10, 10);
    check16("scroll_off8_bg", oled_a, BG_A);
    step("sc_last", 0, 0, 1, 0, 10, 10);
    step("sc_px", 0, 0, 0, 0, 10, 10);
    check16("scroll_hold_fg", oled_a, FG_A);

    // Blink
    step("bl_start", 0, 1, 0, 1, 10, 10);
    for (int k = 0; k <= 8; k++) begin
      step("bl_px", 0, 0, 0, 0, 10, 10);
      check16("blink_10_10", oled_a, (k >= 4 && k < 8) ? BG_A : FG_A);
      step("bl_fb", 0, 0, 1, 0, 40, 20);
    end

    // Invert-flash
    step("inv_start", 0, 1, 0, 3, 10, 10);
    frames("inv_frames", 4);
    step("inv_px", 0, 0, 0, 0, 0, 0);
    check16("invert_origin", oled_a, FG_A);
    step("inv_px", 0, 0, 0, 0, 10, 10);
    check16("invert_text", oled_a, BG_A);
    step("inv_px", 0, 0, 0, 0, 100, 10);
    check16("invert_offscreen", oled_a, BG_A);

    // Reset mid-scroll at offset 40
    step("rs_start", 0, 1, 0, 2, 10, 10);
    frames("rs_frames", 7);
    step("rs_px", 0, 0, 0, 0, 50, 10);
    check16("rs_off40_fg", oled_a, FG_A);
    step("rs_reset", 1, 0, 0, 0, 50, 10);
    check16("rs_bg", oled_a, BG_A);
    check1("rs_active", active_a, 1'b0);
    check1("rs_done", done_a, 1'b0);
    step("rs_restart", 0, 1, 0, 2, 50, 10);
    step("rs_px", 0, 0, 0, 0, 95, 10);
    check16("rs_reload_bg", oled_a, BG_A);

    // start + frame_begin together in DONE
    step("co_start", 0, 1, 0, 0, 10, 10);
    frames("co_frames", HOLD_A);
    check1("co_in_done", done_a, 1'b1);
    step("co_both", 0, 1, 1, 2, 10, 10);
    check1("co_done_drop", done_a, 1'b0);
    step("co_px", 0, 0, 0, 0, 10, 10);
    check16("co_offset96", oled_a, BG_A);
    frames("co_frames2", 2);

    // Randomised traffic
    for (int i = 0; i < 4000; i++) begin
      step("rand", ($urandom_range(0, 199) == 0), ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 127)), int'($urandom_range(0, 63)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
